noc_pe_interface: RTL
=====================

Name: noc_pe_interface

Overview:
- Network interface between a processing element (PE) and the PE port of the mesh switch in the same tile.
- Inject path: takes PE payload plus destination coordinates, builds the packet header, buffers packets in a TX FIFO and presents them to the switch under its combinational ready.
- Eject path: the switch PE output has no backpressure, so every delivered packet is captured into an RX FIFO; overflow and misrouting are counted.

Parameters:
- X_COORD, 0: x coordinate of this tile.
- Y_COORD, 0: y coordinate of this tile.
- DATA_WIDTH, 32: payload width.
- X_SIZE, 1: x field width.
- Y_SIZE, 1: y field width.
- TOTAL_WIDTH, X_SIZE+Y_SIZE+DATA_WIDTH: packet width.
- TX_DEPTH, 4: TX FIFO entries (power of 2, ≥2).
- RX_DEPTH, 4: RX FIFO entries (power of 2, ≥2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- i_pe_valid  in  1  PE has a packet to send
- i_pe_dest_x  in  X_SIZE  destination x
- i_pe_dest_y  in  Y_SIZE  destination y
- i_pe_data  in  DATA_WIDTH  payload
- o_pe_ready  out  1  TX FIFO can accept
- o_sw_valid  out  1  to switch i_valid_pe
- o_sw_data  out  TOTAL_WIDTH  to switch i_data_pe
- i_sw_ready  in  1  from switch o_ready_pe (combinational in switch)
- i_sw_valid  in  1  from switch o_valid_pe
- i_sw_data  in  TOTAL_WIDTH  from switch o_data_pe
- o_rx_valid  out  1  RX head valid
- o_rx_data  out  DATA_WIDTH  RX head payload
- i_rx_ready  in  1  PE consumes RX head
- o_rx_overflow  out  1  sticky: an ejected packet was dropped
- o_drop_count  out  16  ejected packets dropped (saturating)
- o_misroute_count  out  16  ejected packets whose header ≠ (X_COORD,Y_COORD) (saturating)
- o_tx_count  out  16  packets handed to switch (saturating)

Behaviour:
- Packet format: [X_SIZE-1:0]=dest x, [X_SIZE+Y_SIZE-1:X_SIZE]=dest y, [TOTAL_WIDTH-1:X_SIZE+Y_SIZE]=payload.
- Reset (rst=1 at posedge): both FIFOs empty, pointers 0, all counters 0, o_rx_overflow=0. Hence o_sw_valid=0, o_rx_valid=0, o_pe_ready=1 after reset. Data outputs undefined while the matching valid is 0.
- Reset mid-operation discards all buffered packets in both FIFOs; no partial state survives.
- TX push when i_pe_valid & o_pe_ready; header is assembled at push.
- o_pe_ready = !tx_full, driven from registered state only, with no path from i_pe_valid.
- TX FIFO is first-word-fall-through: o_sw_valid = !tx_empty, o_sw_data = head entry, both driven from registers/RAM read only.
- TX pop when o_sw_valid & i_sw_ready. The switch latches the head in the same edge. Latency: PE push at edge N → o_sw_valid high after edge N, when the FIFO was empty.
- o_sw_valid and o_sw_data must not depend combinationally on i_sw_ready; this avoids a loop with the switch's ready logic.
- TX push and pop in the same cycle: allowed when not full; occupancy unchanged. When full, push is blocked (ready=0) even if a pop occurs that cycle.
- o_sw_data is held stable while o_sw_valid=1 and i_sw_ready=0.
- o_tx_count increments on each TX pop and saturates at 16'hFFFF.
- RX push whenever i_sw_valid=1 (no backpressure available).
- RX pop when o_rx_valid & i_rx_ready. o_rx_data = payload field of head, first-word-fall-through.
- RX push and pop in the same cycle when full: the pop frees a slot and the push is accepted with no drop.
- RX push when full with no pop: packet dropped, o_drop_count+1 (saturating), o_rx_overflow set until rst.
- Misroute check on every i_sw_valid cycle, including dropped packets: x or y field ≠ own coordinates → o_misroute_count+1 (saturating). The packet is still stored if space permits.
- FIFO pointers: log2(DEPTH)+1 bits with wrap bit. Full when addresses are equal and wrap bits differ; empty when both are equal. Pointers wrap modulo 2·DEPTH.

Test Plan:
- Reset then idle: rst=1 for 2 cycles → o_pe_ready=1, o_sw_valid=0, o_rx_valid=0, all counters 0, o_rx_overflow=0.
- Inject with X_COORD=0, Y_COORD=0, i_sw_ready=1: send dest (1,0), data 32'hDEADBEEF → next cycle o_sw_valid=1, o_sw_data={32'hDEADBEEF,1'b0,1'b1}; popped that cycle; o_tx_count=1.
- TX backpressure: i_sw_ready=0, push 5 packets with TX_DEPTH=4 → o_pe_ready=0 after the 4th push and the 5th is held. Release ready → o_sw_data order is 1,2,3,4,5 and o_sw_data is stable while stalled.
- RX overflow: i_rx_ready=0, drive 6 consecutive i_sw_valid packets addressed (0,0) → 4 stored, o_drop_count=2, o_rx_overflow=1. Drain → payloads in arrival order.
- Full RX with simultaneous pop and push → no drop, count unchanged, new packet appears last.
- Misroute and mid-operation reset: eject a packet with header (1,1) → o_misroute_count=1. Then assert rst with both FIFOs non-empty → next cycle both valids 0 and all counters 0.

Source files
------------

// File: rtl/noc_pe_interface.sv
// noc_pe_interface
// Network interface between a processing element and the PE port of the
// mesh switch in the same tile.
//
// Inject path: the PE payload and destination are packed into a packet
// {payload, dest_y, dest_x} at push time and buffered in a first-word-fall-
// through TX FIFO that is presented to the switch. The switch's ready is
// combinational, so TX valid/data come only from FIFO state.
//
// Eject path: the switch cannot be backpressured, so every delivered packet
// is captured into an RX FIFO. Packets arriving while the FIFO is full (and
// not being popped that cycle) are dropped and counted. Packets whose header
// does not match this tile are counted as misrouted but still stored.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_pe_valid        PE offers a packet (dest + payload)
//   i_pe_dest_x/y     destination coordinates
//   i_pe_data         payload
//   o_pe_ready        TX FIFO not full (registered state only)
//   o_sw_valid/data   TX FIFO head towards switch
//   i_sw_ready        switch accepts head this cycle
//   i_sw_valid/data   packet ejected by the switch
//   o_rx_valid/data   RX FIFO head payload towards PE
//   i_rx_ready        PE consumes RX head
//   o_rx_overflow     sticky drop flag
//   o_drop_count      dropped ejected packets (saturating)
//   o_misroute_count  ejected packets with foreign header (saturating)
//   o_tx_count        packets handed to the switch (saturating)

// Synchronous FIFO with wrap-bit pointers and a combinational head read.
// Callers gate push/pop; the FIFO itself performs whatever it is told.
//   clk, rst   clock, synchronous active-high reset (empties the FIFO)
//   push       write push_data at the tail
//   pop        advance the head
//   head_data  current head entry (valid when !empty)
//   full/empty occupancy flags from registered pointers
module noc_pe_interface_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage is not reset; the pointer reset alone discards contents.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    assign head_data = mem[rd_ptr[AW-1:0]];
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                       (wr_ptr[AW] != rd_ptr[AW]);

endmodule

module noc_pe_interface #(
    parameter int X_COORD     = 0,
    parameter int Y_COORD     = 0,
    parameter int DATA_WIDTH  = 32,
    parameter int X_SIZE      = 1,
    parameter int Y_SIZE      = 1,
    parameter int TOTAL_WIDTH = X_SIZE + Y_SIZE + DATA_WIDTH,
    parameter int TX_DEPTH    = 4,
    parameter int RX_DEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   i_pe_valid,
    input  logic [X_SIZE-1:0]      i_pe_dest_x,
    input  logic [Y_SIZE-1:0]      i_pe_dest_y,
    input  logic [DATA_WIDTH-1:0]  i_pe_data,
    output logic                   o_pe_ready,

    output logic                   o_sw_valid,
    output logic [TOTAL_WIDTH-1:0] o_sw_data,
    input  logic                   i_sw_ready,

    input  logic                   i_sw_valid,
    input  logic [TOTAL_WIDTH-1:0] i_sw_data,

    output logic                   o_rx_valid,
    output logic [DATA_WIDTH-1:0]  o_rx_data,
    input  logic                   i_rx_ready,

    output logic                   o_rx_overflow,
    output logic [15:0]            o_drop_count,
    output logic [15:0]            o_misroute_count,
    output logic [15:0]            o_tx_count
);

    localparam int HDR_WIDTH = X_SIZE + Y_SIZE;
    localparam logic [X_SIZE-1:0] OWN_X = X_COORD[X_SIZE-1:0];
    localparam logic [Y_SIZE-1:0] OWN_Y = Y_COORD[Y_SIZE-1:0];

    // ------------------------------------------------------------------
    // Inject path
    // ------------------------------------------------------------------
    logic                   tx_full;
    logic                   tx_empty;
    logic                   tx_push;
    logic                   tx_pop;
    logic [TOTAL_WIDTH-1:0] tx_packet;

    assign tx_packet = {i_pe_data, i_pe_dest_y, i_pe_dest_x};

    // Push is gated on the registered full flag only, so a same-cycle pop
    // never lets a push into a full FIFO.
    assign tx_push = i_pe_valid && !tx_full;
    assign tx_pop  = !tx_empty && i_sw_ready;

    noc_pe_interface_fifo #(
        .WIDTH (TOTAL_WIDTH),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_push),
        .push_data (tx_packet),
        .pop       (tx_pop),
        .head_data (o_sw_data),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    assign o_pe_ready = !tx_full;
    assign o_sw_valid = !tx_empty;

    // ------------------------------------------------------------------
    // Eject path
    // ------------------------------------------------------------------
    logic                  rx_full;
    logic                  rx_empty;
    logic                  rx_push;
    logic                  rx_pop;
    logic                  rx_drop;
    logic                  misroute;
    logic [X_SIZE-1:0]     rx_hdr_x;
    logic [Y_SIZE-1:0]     rx_hdr_y;
    logic [DATA_WIDTH-1:0] rx_payload;

    assign rx_hdr_x   = i_sw_data[X_SIZE-1:0];
    assign rx_hdr_y   = i_sw_data[HDR_WIDTH-1:X_SIZE];
    assign rx_payload = i_sw_data[TOTAL_WIDTH-1:HDR_WIDTH];

    assign rx_pop  = !rx_empty && i_rx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign rx_push = i_sw_valid && (!rx_full || rx_pop);
    assign rx_drop = i_sw_valid && rx_full && !rx_pop;

    assign misroute = i_sw_valid && ((rx_hdr_x != OWN_X) || (rx_hdr_y != OWN_Y));

    noc_pe_interface_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (rx_payload),
        .pop       (rx_pop),
        .head_data (o_rx_data),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    assign o_rx_valid = !rx_empty;

    // ------------------------------------------------------------------
    // Status counters (saturating) and sticky overflow
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            o_rx_overflow    <= 1'b0;
            o_drop_count     <= '0;
            o_misroute_count <= '0;
            o_tx_count       <= '0;
        end else begin
            if (rx_drop) begin
                o_rx_overflow <= 1'b1;
                if (o_drop_count != '1) begin
                    o_drop_count <= o_drop_count + 16'd1;
                end
            end
            if (misroute && (o_misroute_count != '1)) begin
                o_misroute_count <= o_misroute_count + 16'd1;
            end
            if (tx_pop && (o_tx_count != '1)) begin
                o_tx_count <= o_tx_count + 16'd1;
            end
        end
    end

endmodule
